// File: rtl/spi_master_burst.sv
// spi_master_burst: parametrised SPI master engine with runtime CPOL/CPHA,
// bit order, word length and multi-word bursts (SS held across words).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i + config      burst start and per-burst settings (latched in IDLE)
//   busy_o, done_o        burst in progress / one-cycle end-of-burst pulse
//   tx_empty_i, tx_data_i, tx_pull_o   TX FIFO (first-word-fall-through)
//   rx_full_i, rx_data_o, rx_push_o    RX FIFO
//   spi_ssel_o, spi_sck_o, spi_mosi_o, spi_miso_i   SPI pins
module spi_master_burst #(
  parameter int g_data_width = 32,
  parameter int g_num_ss     = 4,
  parameter int g_div_width  = 8,
  parameter int g_cnt_width  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic                            cpol_i,
  input  logic                            cpha_i,
  input  logic                            lsb_first_i,
  input  logic [$clog2(g_data_width)-1:0] word_len_i,
  input  logic [g_div_width-1:0]          clk_div_i,
  input  logic [$clog2(g_num_ss)-1:0]     ss_sel_i,
  input  logic [g_cnt_width-1:0]          word_cnt_i,
  output logic                            busy_o,
  output logic                            done_o,
  input  logic                            tx_empty_i,
  input  logic [g_data_width-1:0]         tx_data_i,
  output logic                            tx_pull_o,
  input  logic                            rx_full_i,
  output logic [g_data_width-1:0]         rx_data_o,
  output logic                            rx_push_o,
  output logic [g_num_ss-1:0]             spi_ssel_o,
  output logic                            spi_sck_o,
  output logic                            spi_mosi_o,
  input  logic                            spi_miso_i
);

  localparam int LW = $clog2(g_data_width);
  localparam int SW = $clog2(g_num_ss);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LEAD, S_SHIFT, S_PUSH, S_LAG, S_DONE
  } state_t;

  state_t state, state_nx;

  logic                    cpol, cpha, lsb_first;
  logic [LW-1:0]           word_len;
  logic [g_div_width-1:0]  clk_div, div_cnt;
  logic [SW-1:0]           ss_sel;
  logic [g_cnt_width-1:0]  words_left;
  logic [g_data_width-1:0] tx_word, rx_word;
  logic [LW-1:0]           tx_idx;
  logic [LW:0]             edge_cnt;
  logic                    sck;

  logic          tick, timed, sck_edge, leading, last_edge;
  logic [LW-1:0] tx_pos, rx_pos, rx_idx;

  // Bits are addressed by transmit order k; MSB-first maps k to word_len-k.
  // The first SCK edge is issued as LEAD expires, so SHIFT holds edges 2..2N.
  assign timed     = (state == S_LEAD) || (state == S_SHIFT) || (state == S_LAG);
  assign tick      = (div_cnt == clk_div);
  assign sck_edge  = ((state == S_LEAD) || (state == S_SHIFT)) && tick;
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == {word_len, 1'b1});
  assign rx_idx    = edge_cnt[LW:1];
  assign tx_pos    = lsb_first ? tx_idx : word_len - tx_idx;
  assign rx_pos    = lsb_first ? rx_idx : word_len - rx_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    tx_pull_o  = 1'b0;
    rx_push_o  = 1'b0;
    spi_ssel_o = '1;
    case (state)
      S_IDLE:  if (start_i) state_nx = S_LOAD;
      S_LOAD: begin
        if (!tx_empty_i) begin
          tx_pull_o = 1'b1;
          state_nx  = S_LEAD;
        end
      end
      S_LEAD:  if (tick) state_nx = S_SHIFT;
      S_SHIFT: if (tick && last_edge) state_nx = S_PUSH;
      S_PUSH: begin
        if (!rx_full_i) begin
          rx_push_o = 1'b1;
          state_nx  = (words_left != '0) ? S_LOAD : S_LAG;
        end
      end
      S_LAG:   if (tick) state_nx = S_DONE;
      S_DONE: begin
        done_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_o = (state != S_IDLE) && (state != S_DONE);
    if (busy_o) spi_ssel_o[ss_sel] = 1'b0;
  end

  assign spi_sck_o  = (state == S_SHIFT) ? sck : cpol;
  assign spi_mosi_o = (state == S_IDLE) ? 1'b0 : tx_word[tx_pos];
  assign rx_data_o  = rx_word;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      lsb_first  <= 1'b0;
      word_len   <= '0;
      clk_div    <= '0;
      ss_sel     <= '0;
      words_left <= '0;
      div_cnt    <= '0;
      tx_word    <= '0;
      rx_word    <= '0;
      tx_idx     <= '0;
      edge_cnt   <= '0;
      sck        <= 1'b0;
    end else begin
      if (state == S_IDLE && start_i) begin
        cpol       <= cpol_i;
        cpha       <= cpha_i;
        lsb_first  <= lsb_first_i;
        word_len   <= word_len_i;
        clk_div    <= clk_div_i;
        ss_sel     <= ss_sel_i;
        words_left <= word_cnt_i;
      end

      if (timed && !tick) div_cnt <= div_cnt + 1'b1;
      else                div_cnt <= '0;

      if (tx_pull_o) begin
        tx_word  <= tx_data_i;
        rx_word  <= '0;
        tx_idx   <= '0;
        edge_cnt <= '0;
        sck      <= cpol;
      end

      if (sck_edge) begin
        sck      <= ~sck;
        edge_cnt <= edge_cnt + 1'b1;
        if (leading ^ cpha) rx_word[rx_pos] <= spi_miso_i;
        if (cpha ? (leading && edge_cnt != '0) : (!leading && !last_edge))
          tx_idx <= tx_idx + 1'b1;
      end

      if (rx_push_o && words_left != '0) words_left <= words_left - 1'b1;
    end
  end

endmodule
